// File: rtl/seg_scan_pkg.sv
// Shared types and width helpers for the 7-segment scan driver.
package seg_scan_pkg;

    typedef enum logic {
        StShow,
        StBlank
    } state_e;

    localparam int unsigned DIGIT_W = 4;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter; done_o is high in the last cycle of a loaded interval.
module seg_scan_timer #(
    parameter int unsigned Width  = 8,
    parameter int unsigned RstVal = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= Width'(RstVal);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-aligned display updates.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value_i,
    input  logic [NUM_DIGITS-1:0]         load_mask_i,
    output logic [DIGIT_W-1:0]            digit_o,
    output logic                          digit_en_o,
    output logic [NUM_DIGITS-1:0]         an_n_o,
    output logic                          frame_start_o
);

    localparam int unsigned ValW  = DIGIT_W * NUM_DIGITS;
    localparam int unsigned IdxW  = cnt_w(NUM_DIGITS);
    localparam int unsigned TickW = cnt_w(TICK_DIV);
    localparam int unsigned BlnkW = cnt_w(BLANK_CYCLES);
    localparam int unsigned TmrW  = (TickW > BlnkW) ? TickW : BlnkW;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [ValW-1:0]        disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]  disp_mask_q, disp_mask_d;
    logic                   pend_full_q, pend_full_d;
    logic [ValW-1:0]        pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]  pend_mask_q, pend_mask_d;
    logic [NUM_DIGITS-1:0]  an_n_q, an_n_d;
    logic [DIGIT_W-1:0]     digit_q, digit_d;
    logic                   digit_en_q, digit_en_d;
    logic                   frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0]  lzb_d;
    logic                   commit;
    logic                   vis;
    logic                   tmr_done;
    logic [TmrW-1:0]        tmr_load_val;

    // One timer serves both phases; it reloads on every phase change.
    assign tmr_load_val = (state_q == StShow) ? TmrW'(BLANK_CYCLES - 1) : TmrW'(TICK_DIV - 1);

    seg_scan_timer #(
        .Width  (TmrW),
        .RstVal (BLANK_CYCLES - 1)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_done),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        commit  = 1'b0;
        if (tmr_done) begin
            if (state_q == StShow) begin
                state_d = StBlank;
            end else begin
                state_d = StShow;
                if (idx_q == LastIdx) begin
                    idx_d  = '0;
                    commit = pend_full_q;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
        end
    end

    always_comb begin
        disp_val_d  = disp_val_q;
        disp_mask_d = disp_mask_q;
        pend_full_d = pend_full_q;
        pend_val_d  = pend_val_q;
        pend_mask_d = pend_mask_q;
        if (commit) begin
            disp_val_d  = pend_val_q;
            disp_mask_d = pend_mask_q;
            pend_full_d = 1'b0;
        end else if (load_valid_i && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_val_d  = load_value_i;
            pend_mask_d = load_mask_i;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Blank zero digits from the top down until a nonzero or masked-off digit.
    function automatic logic [NUM_DIGITS-1:0] calc_lzb(input logic [ValW-1:0]       val,
                                                       input logic [NUM_DIGITS-1:0] mask);
        logic run;
        calc_lzb = '0;
        run      = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (run && mask[i] && (val[DIGIT_W*i +: DIGIT_W] == '0)) begin
                calc_lzb[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    endfunction

    logic [NUM_DIGITS-1:0] lzb_q;

    assign lzb_d = commit ? calc_lzb(pend_val_q, pend_mask_q) : lzb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lzb_q <= '0;
        end else begin
            lzb_q <= lzb_d;
        end
    end
`else
    assign lzb_d = '0;
`endif

    // Outputs are built from next-state values so they register on the same edge.
    always_comb begin
        vis           = disp_mask_d[idx_d] & ~lzb_d[idx_d];
        an_n_d        = '1;
        digit_d       = digit_q;
        digit_en_d    = 1'b0;
        frame_start_d = 1'b0;
        if (state_d == StShow) begin
            an_n_d        = vis ? ~(NUM_DIGITS'(1) << idx_d) : '1;
            digit_d       = disp_val_d[DIGIT_W*idx_d +: DIGIT_W];
            digit_en_d    = vis;
            frame_start_d = (state_q == StBlank) && (idx_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBlank;
            idx_q         <= LastIdx;
            disp_val_q    <= '0;
            disp_mask_q   <= '0;
            pend_full_q   <= 1'b0;
            pend_val_q    <= '0;
            pend_mask_q   <= '0;
            an_n_q        <= '1;
            digit_q       <= '0;
            digit_en_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            disp_val_q    <= disp_val_d;
            disp_mask_q   <= disp_mask_d;
            pend_full_q   <= pend_full_d;
            pend_val_q    <= pend_val_d;
            pend_mask_q   <= pend_mask_d;
            an_n_q        <= an_n_d;
            digit_q       <= digit_d;
            digit_en_q    <= digit_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign load_ready_o  = ~pend_full_q;
    assign an_n_o        = an_n_q;
    assign digit_o       = digit_q;
    assign digit_en_o    = digit_en_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with 4 digits, 4-cycle dwell, 2-cycle blank.
module tb_seg_scan_driver;

    localparam int unsigned ND    = 4;
    localparam int unsigned TD    = 4;
    localparam int unsigned BC    = 2;
    localparam int unsigned SLOT  = TD + BC;
    localparam int unsigned FRAME = ND * SLOT;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LIT_0070 = 4'b0011;
    localparam logic [3:0] LIT_0000 = 4'b0001;
`else
    localparam logic [3:0] LIT_0070 = 4'b1111;
    localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  load_mask;
    logic [3:0]  digit;
    logic        digit_en;
    logic [3:0]  an_n;
    logic        frame_start;

    seg_scan_driver #(
        .NUM_DIGITS   (ND),
        .TICK_DIV     (TD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid_i  (load_valid),
        .load_ready_o  (load_ready),
        .load_value_i  (load_value),
        .load_mask_i   (load_mask),
        .digit_o       (digit),
        .digit_en_o    (digit_en),
        .an_n_o        (an_n),
        .frame_start_o (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic pend_model;

    typedef struct {
        string       name;
        logic [15:0] val;     // expected display value this frame
        logic [3:0]  lit;     // expected lit slots this frame
        logic        ld;      // issue a load during this frame
        logic [15:0] ld_val;
        logic [3:0]  ld_mask;
        int          ld_at;
        logic        ld2;     // extra valid two cycles later, must be refused
    } frame_t;

    frame_t frames[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_load(input logic [15:0] v, input logic [3:0] m);
        load_valid = 1'b1;
        load_value = v;
        load_mask  = m;
        if (!pend_model) pend_model = 1'b1;
    endtask

    task automatic chk_dark(input string tag, input logic [3:0] dig, input logic rdy);
        chk({tag, ".an_n"}, 32'(an_n), 32'hf);
        chk({tag, ".digit_en"}, 32'(digit_en), 32'h0);
        chk({tag, ".frame_start"}, 32'(frame_start), 32'h0);
        chk({tag, ".digit"}, 32'(digit), 32'(dig));
        chk({tag, ".load_ready"}, 32'(load_ready), 32'(rdy));
    endtask

    task automatic run_frame(input frame_t f);
        int         slot;
        int         ins;
        logic       exp_en;
        logic [3:0] exp_an;
        logic [15:0] v;
        for (int p = 0; p < int'(FRAME); p++) begin
            step();
            if (p == 0) pend_model = 1'b0;
            slot   = p / int'(SLOT);
            ins    = p % int'(SLOT);
            v      = f.val;
            exp_en = (ins < int'(TD)) && f.lit[slot];
            exp_an = exp_en ? ~(4'b0001 << slot) : 4'hf;
            chk({f.name, ".an_n"}, 32'(an_n), 32'(exp_an));
            chk({f.name, ".digit_en"}, 32'(digit_en), 32'(exp_en));
            chk({f.name, ".digit"}, 32'(digit), 32'(v[4*slot +: 4]));
            chk({f.name, ".frame_start"}, 32'(frame_start), 32'(p == 0));
            chk({f.name, ".load_ready"}, 32'(load_ready), 32'(!pend_model));
            load_valid = 1'b0;
            if (f.ld && p == f.ld_at) drive_load(f.ld_val, f.ld_mask);
            if (f.ld2 && p == f.ld_at + 2) drive_load(16'h5555, 4'hf);
        end
    endtask

    initial begin
        frames[0] = '{"f4321",   16'h4321, 4'b1111, 1'b1, 16'hAAAA, 4'hf, 12, 1'b1};
        frames[1] = '{"fAAAA",   16'hAAAA, 4'b1111, 1'b1, 16'h4321, 4'b0101, 20, 1'b0};
        frames[2] = '{"mask0101", 16'h4321, 4'b0101, 1'b1, 16'h0070, 4'hf, 5, 1'b0};
        frames[3] = '{"v0070",   16'h0070, LIT_0070, 1'b1, 16'h0000, 4'hf, 5, 1'b0};
        frames[4] = '{"v0000",   16'h0000, LIT_0000, 1'b0, 16'h0000, 4'h0, 0, 1'b0};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_value = '0;
        load_mask  = '0;
        pend_model = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_dark("reset", 4'h0, 1'b1);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_dark("rel_c0", 4'h0, 1'b1);
        drive_load(16'h4321, 4'hf);
        step();
        chk_dark("rel_c1", 4'h0, 1'b0);
        load_valid = 1'b0;

        for (int k = 0; k < 5; k++) run_frame(frames[k]);

        // Queue a load, then reset asynchronously during SHOW of idx 1.
        for (int p = 0; p < 8; p++) begin
            step();
            load_valid = 1'b0;
            if (p == 2) drive_load(16'h9999, 4'hf);
        end
        chk("pre_rst.load_ready", 32'(load_ready), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dark("async_rst", 4'h0, 1'b1);
        load_valid = 1'b0;
        pend_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_dark("rel2_c0", 4'h0, 1'b1);
        step();
        chk_dark("rel2_c1", 4'h0, 1'b1);
        run_frame('{"dark1", 16'h0000, 4'b0000, 1'b0, 16'h0, 4'h0, 0, 1'b0});
        run_frame('{"dark2", 16'h0000, 4'b0000, 1'b0, 16'h0, 4'h0, 0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
